// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write channels of the instruction encoder.
// The encoder uses the slave view; whoever issues requests and owns imem uses master.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_class;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        imem_write_en;
  logic [31:0] imem_write_addr;
  logic [31:0] imem_write_data;
  logic        imem_write_ack;

  modport master (
    output req_valid, req_class, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  imem_write_en, imem_write_addr, imem_write_data,
    output imem_write_ack
  );

  modport slave (
    input  req_valid, req_class, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready,
    output imem_write_en, imem_write_addr, imem_write_data,
    input  imem_write_ack
  );
endinterface

// File: rtl/instr_encoder.sv
// Turns decoded instruction requests into RV32I/M machine words and writes them
// to sequential instruction-memory addresses starting at a loadable base.
module instr_encoder (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  instr_encoder_if.slave        bus,
  output logic                  err_illegal,
  output logic [15:0]           instr_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ENC, WR, ERR} state_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IARITH = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  state_t      state;
  logic [31:0] ptr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic [3:0]  c_cls;
  logic [2:0]  c_f3;
  logic [6:0]  c_f7;
  logic [4:0]  c_rd;
  logic [4:0]  c_rs1;
  logic [4:0]  c_rs2;
  logic [31:0] c_imm;

  logic [31:0] word;
  logic        illegal;
  logic        is_shift;

  assign bus.req_ready       = (state == IDLE) && !start && !rst;
  assign bus.imem_write_en   = (state == WR);
  assign bus.imem_write_addr = wr_addr;
  assign bus.imem_write_data = wr_data;
  assign err_illegal         = (state == ERR);
  assign busy                = (state != IDLE);

  assign is_shift = (c_f3 == 3'b001) || (c_f3 == 3'b101);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (c_cls)
      4'd0: begin
        word = {c_f7, c_rs2, c_rs1, c_f3, c_rd, OP_R};
        if (!(c_f7 == 7'h00 || c_f7 == 7'h20 || c_f7 == 7'h01))
          illegal = 1'b1;
        if (c_f7 == 7'h20 && !(c_f3 == 3'b000 || c_f3 == 3'b101))
          illegal = 1'b1;
      end
      4'd1: begin
        if (is_shift) begin
          word = {c_f7, c_imm[4:0], c_rs1, c_f3, c_rd, OP_IARITH};
          // Only SRAI may use the 0x20 funct7; everything else needs zero.
          if (!(c_f7 == 7'h00 || (c_f7 == 7'h20 && c_f3 == 3'b101)))
            illegal = 1'b1;
        end else begin
          word = {c_imm[11:0], c_rs1, c_f3, c_rd, OP_IARITH};
        end
      end
      4'd2: word = {c_imm[11:0], c_rs1, 3'b010, c_rd, OP_LOAD};
      4'd3: word = {c_imm[11:5], c_rs2, c_rs1, 3'b010, c_imm[4:0], OP_STORE};
      4'd4: begin
        word = {c_imm[12], c_imm[10:5], c_rs2, c_rs1, c_f3, c_imm[4:1], c_imm[11], OP_BRANCH};
        if (c_f3 == 3'b010 || c_f3 == 3'b011 || c_imm[0])
          illegal = 1'b1;
      end
      4'd5: begin
        word = {c_imm[20], c_imm[10:1], c_imm[11], c_imm[19:12], c_rd, OP_JAL};
        if (c_imm[0])
          illegal = 1'b1;
      end
      4'd6: word = {c_imm[11:0], c_rs1, 3'b000, c_rd, OP_JALR};
      4'd7: word = {c_imm[31:12], c_rd, OP_LUI};
      4'd8: word = {c_imm[31:12], c_rd, OP_AUIPC};
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      instr_count <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      c_cls       <= '0;
      c_f3        <= '0;
      c_f7        <= '0;
      c_rd        <= '0;
      c_rs1       <= '0;
      c_rs2       <= '0;
      c_imm       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr         <= base_addr;
            instr_count <= '0;
          end else if (bus.req_valid) begin
            c_cls <= bus.req_class;
            c_f3  <= bus.req_funct3;
            c_f7  <= bus.req_funct7;
            c_rd  <= bus.req_rd;
            c_rs1 <= bus.req_rs1;
            c_rs2 <= bus.req_rs2;
            c_imm <= bus.req_imm;
            state <= ENC;
          end
        end
        ENC: begin
          // The write registers are only loaded for legal words so that a
          // rejected request leaves the previous address/data on the bus.
          if (illegal) begin
            state <= ERR;
          end else begin
            wr_data <= word;
            wr_addr <= ptr;
            state   <= WR;
          end
        end
        WR: begin
          if (bus.imem_write_ack) begin
            ptr <= ptr + 32'd4;
            if (instr_count != '1)
              instr_count <= instr_count + 16'd1;
            state <= IDLE;
          end
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder: encodings, illegal
// rejection, write handshake timing, address wrap and reset during a write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        err_illegal;
  logic [15:0] instr_count;
  logic        busy;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .bus         (bus),
    .err_illegal (err_illegal),
    .instr_count (instr_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        bad;
    logic [31:0] word;
  } vec_t;

  int nvec  = 0;
  int nfail = 0;

  vec_t        tbl [20];
  logic [31:0] m_ptr;
  logic [15:0] m_cnt;
  logic [31:0] last_addr;
  logic [31:0] last_data;

  function automatic vec_t mk(logic [3:0] c, logic [2:0] f3, logic [6:0] f7,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic bad, logic [31:0] w);
    vec_t v;
    v.cls = c; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.bad = bad; v.word = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_class  = v.cls;
    bus.req_funct3 = v.f3;
    bus.req_funct7 = v.f7;
    bus.req_rd     = v.rd;
    bus.req_rs1    = v.rs1;
    bus.req_rs2    = v.rs2;
    bus.req_imm    = v.imm;
    bus.req_valid  = 1'b1;
  endtask

  // Issue one request, ack the resulting write after dly waiting cycles.
  task automatic send(input vec_t v, input int dly, output logic saw_wr,
                      output logic saw_err, output logic [31:0] wa,
                      output logic [31:0] wd);
    int lat;
    saw_wr = 1'b0; saw_err = 1'b0; wa = '0; wd = '0; lat = 0;
    drive_req(v);
    for (int n = 0; n < 50 && !bus.req_ready; n++) @(negedge clk);
    chk("accept_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (bus.imem_write_en) begin saw_wr = 1'b1; break; end
      if (err_illegal)       begin saw_err = 1'b1; break; end
    end
    chk("latency", lat, 32'd2);
    if (saw_wr) begin
      wa = bus.imem_write_addr;
      wd = bus.imem_write_data;
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        chk("hold_en",   {31'd0, bus.imem_write_en}, 32'd1);
        chk("hold_addr", bus.imem_write_addr, wa);
        chk("hold_data", bus.imem_write_data, wd);
        chk("ready_in_wr", {31'd0, bus.req_ready}, 32'd0);
      end
      bus.imem_write_ack = 1'b1;
      @(posedge clk);
      #1 bus.imem_write_ack = 1'b0;
    end else if (saw_err) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("err_pulse_end", {31'd0, err_illegal}, 32'd0);
    chk("en_low_after", {31'd0, bus.imem_write_en}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        w, e;
    logic [31:0] a, d;
    vec_t        add_v;

    tbl[0]  = mk(4'd0, 3'b000, 7'h00, 5'd3,  5'd1, 5'd2, 32'h0,        1'b0, 32'h002081B3); // ADD
    tbl[1]  = mk(4'd1, 3'b000, 7'h00, 5'd5,  5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00293); // ADDI -1
    tbl[2]  = mk(4'd4, 3'b000, 7'h00, 5'd0,  5'd1, 5'd2, 32'd8,        1'b0, 32'h00208463); // BEQ +8
    tbl[3]  = mk(4'd5, 3'b000, 7'h00, 5'd1,  5'd0, 5'd0, 32'd2048,     1'b0, 32'h001000EF); // JAL
    tbl[4]  = mk(4'd5, 3'b000, 7'h00, 5'd1,  5'd0, 5'd0, 32'd3,        1'b1, 32'h0);        // JAL odd
    tbl[5]  = mk(4'd9, 3'b000, 7'h00, 5'd1,  5'd1, 5'd1, 32'd0,        1'b1, 32'h0);        // class 9
    tbl[6]  = mk(4'd0, 3'b111, 7'h20, 5'd1,  5'd2, 5'd3, 32'd0,        1'b1, 32'h0);        // f7 20 f3 7
    tbl[7]  = mk(4'd0, 3'b000, 7'h20, 5'd1,  5'd2, 5'd3, 32'd0,        1'b0, 32'h403100B3); // SUB
    tbl[8]  = mk(4'd2, 3'b000, 7'h00, 5'd6,  5'd7, 5'd9, 32'd12,       1'b0, 32'h00C3A303); // LW
    tbl[9]  = mk(4'd3, 3'b000, 7'h00, 5'd7,  5'd2, 5'd5, 32'd8,        1'b0, 32'h00512423); // SW
    tbl[10] = mk(4'd7, 3'b000, 7'h00, 5'd10, 5'd3, 5'd4, 32'h12345678, 1'b0, 32'h12345537); // LUI
    tbl[11] = mk(4'd8, 3'b000, 7'h00, 5'd1,  5'd0, 5'd0, 32'hABCDE000, 1'b0, 32'hABCDE097); // AUIPC
    tbl[12] = mk(4'd6, 3'b011, 7'h00, 5'd1,  5'd5, 5'd6, 32'd4,        1'b0, 32'h004280E7); // JALR
    tbl[13] = mk(4'd1, 3'b001, 7'h00, 5'd1,  5'd2, 5'd0, 32'hFFFFFFE3, 1'b0, 32'h00311093); // SLLI 3
    tbl[14] = mk(4'd1, 3'b001, 7'h20, 5'd1,  5'd2, 5'd0, 32'd3,        1'b1, 32'h0);        // SLLI f7 20
    tbl[15] = mk(4'd4, 3'b010, 7'h00, 5'd0,  5'd1, 5'd2, 32'd8,        1'b1, 32'h0);        // BR f3 2
    tbl[16] = mk(4'd4, 3'b001, 7'h00, 5'd0,  5'd3, 5'd4, 32'hFFFFFFFC, 1'b0, 32'hFE419EE3); // BNE -4
    tbl[17] = mk(4'd0, 3'b000, 7'h01, 5'd1,  5'd2, 5'd3, 32'd0,        1'b0, 32'h023100B3); // MUL
    tbl[18] = mk(4'd0, 3'b000, 7'h02, 5'd1,  5'd2, 5'd3, 32'd0,        1'b1, 32'h0);        // bad f7
    tbl[19] = mk(4'd5, 3'b000, 7'h00, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFE, 1'b0, 32'hFFFFF06F); // JAL -2
    add_v = tbl[0];

    rst = 1'b1; start = 1'b0; base_addr = '0;
    bus.req_valid = 1'b0; bus.imem_write_ack = 1'b0;
    bus.req_class = '0; bus.req_funct3 = '0; bus.req_funct7 = '0;
    bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en",    {31'd0, bus.imem_write_en}, 32'd0);
    chk("rst_err",   {31'd0, err_illegal}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    chk("rst_addr",  bus.imem_write_addr, 32'd0);
    chk("rst_data",  bus.imem_write_data, 32'd0);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    start = 1'b1; base_addr = 32'h100;
    #1 chk("ready_during_start", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    m_ptr = 32'h100; m_cnt = '0;
    last_addr = '0; last_data = '0;

    for (int i = 0; i < 20; i++) begin
      send(tbl[i], 0, w, e, a, d);
      if (tbl[i].bad) begin
        chk("illegal_err",   {31'd0, e}, 32'd1);
        chk("illegal_nowr",  {31'd0, w}, 32'd0);
        chk("illegal_count", {16'd0, instr_count}, {16'd0, m_cnt});
        chk("illegal_addr_hold", bus.imem_write_addr, last_addr);
        chk("illegal_data_hold", bus.imem_write_data, last_data);
      end else begin
        chk("wr_seen", {31'd0, w}, 32'd1);
        chk("wr_data", d, tbl[i].word);
        chk("wr_addr", a, m_ptr);
        m_ptr = m_ptr + 32'd4;
        m_cnt = m_cnt + 16'd1;
        last_addr = a; last_data = d;
        chk("wr_count", {16'd0, instr_count}, {16'd0, m_cnt});
      end
    end

    // Acknowledge held off for three cycles.
    send(add_v, 3, w, e, a, d);
    chk("dly_data", d, 32'h002081B3);
    chk("dly_addr", a, m_ptr);
    m_ptr = m_ptr + 32'd4;
    m_cnt = m_cnt + 16'd1;
    chk("dly_count", {16'd0, instr_count}, {16'd0, m_cnt});

    // Pointer wrap at the top of the address space.
    start = 1'b1; base_addr = 32'hFFFFFFFC;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_clears_count", {16'd0, instr_count}, 32'd0);
    send(add_v, 0, w, e, a, d);
    chk("wrap_addr0", a, 32'hFFFFFFFC);
    send(tbl[1], 0, w, e, a, d);
    chk("wrap_addr1", a, 32'h00000000);
    chk("wrap_data1", d, 32'hFFF00293);
    chk("wrap_count", {16'd0, instr_count}, 32'd2);

    // Reset while a write is pending, then a stray ack in IDLE.
    drive_req(add_v);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_write_en) begin w = 1'b1; break; end
    end
    chk("midwr_en_seen", {31'd0, w}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midwr_rst_en",    {31'd0, bus.imem_write_en}, 32'd0);
    chk("midwr_rst_count", {16'd0, instr_count}, 32'd0);
    chk("midwr_rst_busy",  {31'd0, busy}, 32'd0);
    chk("midwr_rst_addr",  bus.imem_write_addr, 32'd0);
    chk("midwr_rst_data",  bus.imem_write_data, 32'd0);
    chk("midwr_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_write_ack = 1'b1;
    @(posedge clk);
    #1 bus.imem_write_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_count", {16'd0, instr_count}, 32'd0);
    chk("stray_ack_en",    {31'd0, bus.imem_write_en}, 32'd0);
    chk("stray_ack_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Clock and reset SHALL be a single clock `clk`, with reset `rst` synchronous and active-high; the block SHALL have no other clock or asynchronous input.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  load write pointer from base_addr, clear instr_count
- base_addr  in  32  first imem word address
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_class  in  4  0=R, 1=I-arith, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC
- req_funct3  in  3  funct3
- req_funct7  in  7  funct7 for R and shift-immediates
- req_rd, req_rs1, req_rs2  in  5 each  register fields
- req_imm  in  32  byte-offset/immediate, two's complement
- imem_write_en  out  1  write request, held until ack
- imem_write_addr  out  32  word byte-address
- imem_write_data  out  32  encoded instruction
- imem_write_ack  in  1  write accepted this cycle
- err_illegal  out  1  one-cycle pulse, request rejected
- instr_count  out  16  instructions written since start/reset
- busy  out  1  state != IDLE

Function
REQ-003 FSM states SHALL be IDLE, ENC, WR, ERR.
REQ-004 IDLE: req_ready = !start; on start, write pointer <= base_addr and instr_count <= 0; start takes priority over req_valid in the same cycle.
REQ-005 IDLE, on req_valid & req_ready: all req_* fields SHALL be captured into registers and the FSM SHALL go to ENC.
REQ-006 ENC (one cycle): the 32-bit word and an illegal flag SHALL be computed from the captured fields and registered. Next state is ERR if illegal, else WR.
REQ-007 WR: imem_write_en = 1, with addr/data stable until imem_write_ack. On ack: pointer += 4 (mod 2^32), instr_count += 1 (saturating at 0xFFFF), next state IDLE.
REQ-008 ERR (one cycle): err_illegal = 1; no write; pointer and count unchanged; next state IDLE.
REQ-009 Latency: accept at edge N, imem_write_en high at N+2; minimum 3 cycles per instruction, ack same cycle.
REQ-010 Encodings (opcode in [6:0], rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20]):
- R (0x33): {funct7, rs2, rs1, f3, rd}.
- I-arith (0x13): {imm[11:0], rs1, f3, rd}; for f3 = 001/101, [31:25] = funct7 and [24:20] = imm[4:0].
- LOAD (0x03): f3 forced 010.
- STORE (0x23): f3 forced 010, {imm[11:5], rs2, rs1, 010, imm[4:0]}.
- BRANCH (0x63): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
- JAL (0x6F): {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
- JALR (0x67): f3 forced 000.
- LUI (0x37) / AUIPC (0x17): {imm[31:12], rd}.
- Unused register fields SHALL be zero.
- Immediate bits above the field width SHALL be truncated without error.
REQ-011 Illegal conditions:
- class > 8
- R with funct7 not in {0x00, 0x20, 0x01}
- R with funct7 = 0x20 and f3 not in {000, 101}
- I-shift with funct7 not 0x00, or funct7 0x20 with f3 = 001
- BRANCH with f3 = 010/011
- BRANCH or JAL with imm[0] = 1
REQ-012 When not in WR: imem_write_en = 0, and imem_write_data and imem_write_addr hold their last values.
REQ-013 imem_write_ack outside WR SHALL be ignored.
REQ-014 start outside IDLE SHALL be ignored.

Reset
REQ-015 rst SHALL have priority over all inputs, including mid-WR. Next edge:
- state = IDLE
- imem_write_en = 0, err_illegal = 0, busy = 0
- write pointer = 0, instr_count = 0
- imem_write_addr = 0, imem_write_data = 0
REQ-016 req_ready SHALL be 0 while rst is high and 1 on the first cycle after rst falls (if start = 0).

Verification
REQ-017 start with base_addr = 0x100; ADD x3,x1,x2 (class 0, f3 0, f7 0x00) with ack same cycle -> write 0x002081B3 @0x100, instr_count = 1, req_ready high 3 cycles after accept.
REQ-018 ADDI x5,x0,-1 (imm 0xFFFFFFFF) -> 0xFFF00293; then BEQ x1,x2,+8 -> 0x00208463 at next address +4.
REQ-019 JAL x1,+2048 -> 0x001000EF; JAL with imm = 3 -> err_illegal one cycle, no write, pointer unchanged.
REQ-020 class = 9, and SUB-style funct7 = 0x20 with f3 = 111 -> err_illegal each, instr_count unchanged.
REQ-021 ack delayed 3 cycles -> addr/data stable, req_ready = 0 throughout; base_addr = 0xFFFFFFFC, two writes -> second at 0x00000000.
REQ-022 rst asserted in WR before ack -> imem_write_en = 0 next cycle, instr_count = 0; ack after reset produces no count change.
